pwm_deadtime_gen: RTL and testbench

Converts each raw PWM channel into a complementary high-side/low-side gate-drive pair with programmable dead time and a latched fault shutdown. Sits directly downstream of the PWM stage and consumes its 3-bit channel output. Drives the pad outputs that would otherwise carry the raw PWM signals. Guarantees that `hs_out[i]` and `ls_out[i]` are never high in the same cycle.

---
 rtl/pwm_deadtime_gen_pkg.sv | 16 +
 rtl/pwm_deadtime_gen_if.sv | 29 ++
 rtl/pwm_deadtime_gen_channel.sv | 93 +++++++++
 rtl/pwm_deadtime_gen.sv | 63 ++++++
 tb/tb_pwm_deadtime_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared definitions for the dead-time generator: per-channel FSM state
// encodings and default widths.
package pwm_defs;

  localparam int CHANNELS_DEF = 3;
  localparam int DT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_DT_H = 3'd1,
    ST_HIGH = 3'd2,
    ST_DT_L = 3'd3,
    ST_LOW  = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Control/status bundle between the PWM stage, the fault source and the
// dead-time generator. The generator is the slave side.
interface pwm_deadtime_if
  import pwm_defs::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
);

  logic                enable;
  logic [CHANNELS-1:0] pwm_in;
  logic [DT_WIDTH-1:0] dead_time;
  logic                fault_n;
  logic                fault_clear;
  logic [CHANNELS-1:0] hs_out;
  logic [CHANNELS-1:0] ls_out;
  logic                fault_latched;

  modport master (
    output enable, pwm_in, dead_time, fault_n, fault_clear,
    input  hs_out, ls_out, fault_latched
  );

  modport slave (
    input  enable, pwm_in, dead_time, fault_n, fault_clear,
    output hs_out, ls_out, fault_latched
  );

endinterface

// File: rtl/pwm_deadtime_gen_channel.sv
// One complementary gate-drive channel: a five-state FSM with a dead-time
// down-counter. hs and ls come from flops loaded with the decode of the next
// state, so they can never be high together.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   OFF     | both switches off (reset, disabled or faulted)
//   DT_H    | dead time before turning the high side on
//   HIGH    | high side driven
//   DT_L    | dead time before turning the low side on
//   LOW     | low side driven
module pwm_deadtime_channel
  import pwm_defs::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  logic                pwm,
  input  logic [DT_WIDTH-1:0] dead_time,
  output logic                hs,
  output logic                ls
);

  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                hs_q, hs_d;
  logic                ls_q, ls_d;

  // State, counter and drive registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
    end
  end

  // Next-state logic; kill overrides everything. An abort during a dead time
  // returns to the side just released, since the other side was never driven.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = pwm ? ST_DT_H : ST_DT_L;
          cnt_d   = dead_time;
        end
        ST_HIGH: begin
          if (!pwm) begin
            state_d = ST_DT_L;
            cnt_d   = dead_time;
          end
        end
        ST_LOW: begin
          if (pwm) begin
            state_d = ST_DT_H;
            cnt_d   = dead_time;
          end
        end
        ST_DT_L: begin
          if (pwm)                  state_d = ST_HIGH;
          else if (cnt_q <= CNT_ONE) state_d = ST_LOW;
          else                      cnt_d   = cnt_q - CNT_ONE;
        end
        ST_DT_H: begin
          if (!pwm)                 state_d = ST_LOW;
          else if (cnt_q <= CNT_ONE) state_d = ST_HIGH;
          else                      cnt_d   = cnt_q - CNT_ONE;
        end
        default: state_d = ST_OFF;
      endcase
    end
    hs_d = (state_d == ST_HIGH);
    ls_d = (state_d == ST_LOW);
  end

  assign hs = hs_q;
  assign ls = ls_q;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator: fault synchronizer and sticky fault
// latch, a shared kill term, and one dead-time channel per PWM input.
module pwm_deadtime_gen
  import pwm_defs::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  pwm_deadtime_if.slave  bus
);

  logic sync1_q, sync1_d;
  logic f_sync_q, f_sync_d;
  logic fault_q, fault_d;
  logic kill;

  logic [CHANNELS-1:0] hs_vec;
  logic [CHANNELS-1:0] ls_vec;

  // Two-flop synchronizer for the asynchronous fault input plus the latch.
  // Synchronizer resets to 1 so reset itself does not look like a fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      f_sync_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      f_sync_q <= f_sync_d;
      fault_q  <= fault_d;
    end
  end

  // Latch sets while the synchronized fault is low; a clear is honoured only
  // when the fault has already gone away, so set always wins.
  always_comb begin
    sync1_d  = bus.fault_n;
    f_sync_d = sync1_q;
    fault_d  = !f_sync_q || (fault_q && !(bus.fault_clear && f_sync_q));
    kill     = !bus.enable || fault_q || !f_sync_q;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_deadtime_channel #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .kill      (kill),
      .pwm       (bus.pwm_in[g]),
      .dead_time (bus.dead_time),
      .hs        (hs_vec[g]),
      .ls        (ls_vec[g])
    );
  end

  assign bus.hs_out        = hs_vec;
  assign bus.ls_out        = ls_vec;
  assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: a vector table for the basic
// sequencing, then hand-written sequences for multi-cycle corner cases.
module tb_pwm_deadtime_gen;

  logic clk;
  logic rst;

  pwm_deadtime_if #(.CHANNELS(3), .DT_WIDTH(8)) bus ();

  pwm_deadtime_gen #(.CHANNELS(3), .DT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Never both switches of a channel on in the same cycle.
  always @(negedge clk) begin
    if (!rst) chk("overlap", int'(bus.hs_out & bus.ls_out), 0);
  end

  typedef struct {
    logic       en;
    logic [2:0] pwm;
    logic [7:0] dt;
    logic [2:0] hs;
    logic [2:0] ls;
    logic       fl;
  } vec_t;

  vec_t tbl[18];

  // Drive ch0 until the wanted side turns on, counting both-off samples.
  task automatic measure(input bit want_hs, input int change_at,
                         input logic [7:0] new_dt, output int gap,
                         output bit done);
    gap  = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == change_at) bus.dead_time = new_dt;
      step();
      if (want_hs ? bus.hs_out[0] : bus.ls_out[0]) begin
        done = 1'b1;
        break;
      end
      if (!bus.hs_out[0] && !bus.ls_out[0]) gap++;
    end
  endtask

  initial begin
    int  gap;
    int  ngaps;
    int  ls_seen;
    int  zeros;
    bit  seen;
    bit  done;

    tbl[0]  = '{1'b1, 3'b001, 8'd4, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{1'b1, 3'b001, 8'd4, 3'b000, 3'b000, 1'b0};
    tbl[2]  = '{1'b1, 3'b001, 8'd4, 3'b000, 3'b000, 1'b0};
    tbl[3]  = '{1'b1, 3'b001, 8'd4, 3'b000, 3'b000, 1'b0};
    tbl[4]  = '{1'b1, 3'b001, 8'd4, 3'b001, 3'b110, 1'b0};
    tbl[5]  = '{1'b1, 3'b000, 8'd4, 3'b000, 3'b110, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 8'd4, 3'b000, 3'b110, 1'b0};
    tbl[7]  = '{1'b1, 3'b000, 8'd4, 3'b000, 3'b110, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 8'd4, 3'b000, 3'b110, 1'b0};
    tbl[9]  = '{1'b1, 3'b000, 8'd4, 3'b000, 3'b111, 1'b0};
    tbl[10] = '{1'b1, 3'b010, 8'd0, 3'b000, 3'b101, 1'b0};
    tbl[11] = '{1'b1, 3'b010, 8'd0, 3'b010, 3'b101, 1'b0};
    tbl[12] = '{1'b1, 3'b011, 8'd1, 3'b010, 3'b100, 1'b0};
    tbl[13] = '{1'b1, 3'b011, 8'd1, 3'b011, 3'b100, 1'b0};
    tbl[14] = '{1'b0, 3'b011, 8'd1, 3'b000, 3'b000, 1'b0};
    tbl[15] = '{1'b1, 3'b011, 8'd2, 3'b000, 3'b000, 1'b0};
    tbl[16] = '{1'b1, 3'b011, 8'd2, 3'b000, 3'b000, 1'b0};
    tbl[17] = '{1'b1, 3'b011, 8'd2, 3'b011, 3'b100, 1'b0};

    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.pwm_in      = 3'b000;
    bus.dead_time   = 8'd0;
    bus.fault_n     = 1'b1;
    bus.fault_clear = 1'b0;
    step();
    step();
    chk("reset_hs", int'(bus.hs_out), 0);
    chk("reset_ls", int'(bus.ls_out), 0);
    chk("reset_fl", int'(bus.fault_latched), 0);
    rst = 1'b0;

    // Basic sequencing, D=0 and D=1 gaps, enable drop in LOW and recovery.
    for (int i = 0; i < 18; i++) begin
      bus.enable    = tbl[i].en;
      bus.pwm_in    = tbl[i].pwm;
      bus.dead_time = tbl[i].dt;
      step();
      chk($sformatf("tbl%0d_hs", i), int'(bus.hs_out), int'(tbl[i].hs));
      chk($sformatf("tbl%0d_ls", i), int'(bus.ls_out), int'(tbl[i].ls));
      chk($sformatf("tbl%0d_fl", i), int'(bus.fault_latched), int'(tbl[i].fl));
    end

    // Square wave on ch0, period 40, D=5: each gap is exactly 5 cycles.
    bus.dead_time = 8'd5;
    gap   = 0;
    ngaps = 0;
    seen  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus.pwm_in[0] = ((i / 20) % 2) == 1;
      step();
      if (bus.hs_out[0] || bus.ls_out[0]) begin
        if (gap != 0 && seen) begin
          chk("square_gap", gap, 5);
          ngaps++;
        end
        gap  = 0;
        seen = 1'b1;
      end else begin
        gap++;
      end
    end
    chk("square_ngaps", ngaps, 4);
    chk("square_end_hs", int'(bus.hs_out[0]), 1);

    // Two-cycle low pulse in HIGH with D=6: aborts back to HIGH.
    bus.dead_time = 8'd6;
    ls_seen = 0;
    bus.pwm_in[0] = 1'b0;
    step();
    chk("abort_hs_a", int'(bus.hs_out[0]), 0);
    ls_seen += int'(bus.ls_out[0]);
    step();
    chk("abort_hs_b", int'(bus.hs_out[0]), 0);
    ls_seen += int'(bus.ls_out[0]);
    bus.pwm_in[0] = 1'b1;
    step();
    chk("abort_hs_c", int'(bus.hs_out[0]), 1);
    for (int i = 0; i < 8; i++) begin
      ls_seen += int'(bus.ls_out[0]);
      step();
    end
    chk("abort_ls_never", ls_seen, 0);
    chk("abort_hs_end", int'(bus.hs_out[0]), 1);

    // D changed 7 -> 2 mid-count: current gap stays 7, next one is 2.
    bus.pwm_in[0] = 1'b0;
    bus.dead_time = 8'd7;
    measure(1'b0, 3, 8'd2, gap, done);
    chk("dtchg_done1", int'(done), 1);
    chk("dtchg_gap7", gap, 7);
    bus.pwm_in[0] = 1'b1;
    measure(1'b1, -1, 8'd2, gap, done);
    chk("dtchg_done2", int'(done), 1);
    chk("dtchg_gap2", gap, 2);

    // One-cycle fault pulse: outputs off and latch set by the third edge.
    bus.fault_n = 1'b0;
    step();
    chk("flt_n_fl", int'(bus.fault_latched), 0);
    chk("flt_n_hs", int'(bus.hs_out), 3'b011);
    bus.fault_n = 1'b1;
    step();
    chk("flt_n1_fl", int'(bus.fault_latched), 0);
    step();
    chk("flt_n2_fl", int'(bus.fault_latched), 1);
    chk("flt_n2_hs", int'(bus.hs_out), 0);
    chk("flt_n2_ls", int'(bus.ls_out), 0);

    // Clear while the fault is still present is ignored.
    bus.fault_n = 1'b0;
    step();
    step();
    step();
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    chk("clr_ignored_fl", int'(bus.fault_latched), 1);
    chk("clr_ignored_hs", int'(bus.hs_out), 0);

    // Clear after the fault is gone: outputs return after a full dead time.
    bus.fault_n = 1'b1;
    step();
    step();
    chk("clr_wait_fl", int'(bus.fault_latched), 1);
    bus.fault_clear = 1'b1;
    bus.dead_time   = 8'd3;
    step();
    bus.fault_clear = 1'b0;
    chk("clr_ok_fl", int'(bus.fault_latched), 0);
    chk("clr_ok_hs", int'(bus.hs_out), 0);
    zeros = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.hs_out == 3'b000 && bus.ls_out == 3'b000) zeros++;
    end
    chk("clr_dt_zeros", zeros, 3);
    step();
    chk("clr_resume_hs", int'(bus.hs_out), 3'b011);
    chk("clr_resume_ls", int'(bus.ls_out), 3'b100);

    // Reset pulsed mid DT_L: immediate off, recovery through dead time.
    bus.pwm_in    = 3'b000;
    bus.dead_time = 8'd5;
    step();
    chk("rst_pre_ls", int'(bus.ls_out), 3'b100);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_imm_hs", int'(bus.hs_out), 0);
    chk("rst_imm_ls", int'(bus.ls_out), 0);
    chk("rst_imm_fl", int'(bus.fault_latched), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    zeros = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.hs_out == 3'b000 && bus.ls_out == 3'b000) zeros++;
    end
    chk("rst_dt_zeros", zeros, 5);
    step();
    chk("rst_resume_ls", int'(bus.ls_out), 3'b111);
    chk("rst_resume_hs", int'(bus.hs_out), 0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
